// File: rtl/fixed_max_normalize_pkg.sv
// Shared types and helpers for fixed_max_normalize: FSM state enum and saturate-to-width.
package fixed_max_normalize_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int unsigned SAT_W = 64;

  // Clamp a signed value into the two's-complement range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/fixed_lane_max.sv
// Combinational signed maximum across all lanes of one beat.
module fixed_lane_max #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic signed [WIDTH-1:0] lanes [LANES],
  output logic signed [WIDTH-1:0] max_c
);

  always_comb begin
    max_c = lanes[0];
    for (int i = 1; i < int'(LANES); i++) begin
      if (lanes[i] > max_c) begin
        max_c = lanes[i];
      end
    end
  end

endmodule

// File: rtl/fixed_max_normalize.sv
// Buffers one vector, finds its max, then streams x - max per element.
// Define FIXED_MAX_NORMALIZE_SAT_EN to saturate the difference instead of wrapping it.
module fixed_max_normalize
  import fixed_max_normalize_pkg::*;
#(
  parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
  parameter int unsigned DATA_IN_0_PRECISION_1       = 4,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0],
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
);

  localparam int unsigned P          = DATA_IN_0_PRECISION_0;
  localparam int unsigned L          = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int unsigned FRAC_W     = DATA_IN_0_PRECISION_1;
  localparam int unsigned IN_0_DEPTH = DATA_IN_0_TENSOR_SIZE_DIM_0 / L;
  localparam int unsigned IDX_W      = (IN_0_DEPTH > 1) ? $clog2(IN_0_DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(IN_0_DEPTH - 1);
  localparam logic signed [P-1:0] MOST_NEG = {1'b1, {(P-1){1'b0}}};

  // Fraction bits only ride along with the data; just sanity-check the shape.
  if (FRAC_W >= P || (DATA_IN_0_TENSOR_SIZE_DIM_0 % L) != 0) begin : g_bad_cfg
    $error("fixed_max_normalize: invalid configuration");
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, src_idx_c;
  logic signed [P-1:0] max_q, lane_max_c, run_max_c, ref_max_c;
  logic signed [P-1:0] in_s   [L];
  logic signed [P-1:0] src_c  [L];
  logic signed [P:0]   diff_c [L];
  logic [P-1:0]        res_c  [L];
  logic signed [P-1:0] buffer [IN_0_DEPTH][L];
  logic                in_fire_c, out_fire_c, load_out_c;

  assign in_fire_c  = data_in_0_valid && (state_q == FILL);
  assign out_fire_c = data_out_0_ready && (state_q == DRAIN);

  always_comb begin
    for (int k = 0; k < int'(L); k++) begin
      in_s[k] = $signed(data_in_0[k]);
    end
  end

  if (L == 1) begin : g_lane_bypass
    assign lane_max_c = in_s[0];
  end else begin : g_lane_tree
    fixed_lane_max #(
      .WIDTH (P),
      .LANES (L)
    ) u_lane_max (
      .lanes (in_s),
      .max_c (lane_max_c)
    );
  end

  // First beat of a vector reloads the max so nothing carries over.
  assign run_max_c = (wr_idx_q == '0 || lane_max_c > max_q) ? lane_max_c : max_q;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    load_out_c = 1'b0;
    case (state_q)
      FILL: begin
        if (in_fire_c) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d   = '0;
            state_d    = DRAIN;
            load_out_c = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire_c) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = FILL;
          end else begin
            rd_idx_d   = rd_idx_q + IDX_W'(1);
            load_out_c = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output register is preloaded with the beat that will be presented next.
  always_comb begin
    src_idx_c = (state_q == DRAIN) ? rd_idx_q + IDX_W'(1) : '0;
    ref_max_c = (state_q == DRAIN) ? max_q : run_max_c;
    for (int k = 0; k < int'(L); k++) begin
      src_c[k]  = (IN_0_DEPTH == 1) ? in_s[k] : buffer[src_idx_c][k];
      diff_c[k] = (P+1)'(src_c[k]) - (P+1)'(ref_max_c);
`ifdef FIXED_MAX_NORMALIZE_SAT_EN
      res_c[k]  = P'(sat_to_width(SAT_W'(diff_c[k]), P));
`else
      res_c[k]  = P'(diff_c[k]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= FILL;
      wr_idx_q         <= '0;
      rd_idx_q         <= '0;
      max_q            <= MOST_NEG;
      data_out_0_valid <= 1'b0;
      data_in_0_ready  <= 1'b1;
    end else begin
      state_q          <= state_d;
      wr_idx_q         <= wr_idx_d;
      rd_idx_q         <= rd_idx_d;
      if (in_fire_c) begin
        max_q <= run_max_c;
      end
      data_out_0_valid <= (state_d == DRAIN);
      data_in_0_ready  <= (state_d == FILL);
    end
  end

  // Data storage needs no reset.
  always_ff @(posedge clk) begin
    if (in_fire_c) begin
      for (int k = 0; k < int'(L); k++) begin
        buffer[wr_idx_q][k] <= in_s[k];
      end
    end
    if (load_out_c) begin
      for (int k = 0; k < int'(L); k++) begin
        data_out_0[k] <= res_c[k];
      end
    end
  end

endmodule

// File: doc/fixed_max_normalize.md
FIXED_MAX_NORMALIZE -- requirements
Module: fixed_max_normalize

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: signed two's-complement element width.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 4: fraction bits; these pass through unchanged.
REQ-003 SHALL have parameter DATA_IN_0_TENSOR_SIZE_DIM_0, default 10: vector length.
REQ-004 SHALL have parameter DATA_IN_0_PARALLELISM_DIM_0, default 1: lanes per beat.
REQ-005 SHALL have localparam IN_0_DEPTH = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0: beats per vector; TENSOR_SIZE_DIM_0 SHALL be an exact multiple of PARALLELISM_DIM_0.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk  input  1  rising-edge clock.
REQ-008 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-009 SHALL have port data_in_0  input  [PRECISION_0-1:0] x PARALLELISM_DIM_0 unpacked  input beat.
REQ-010 SHALL have port data_in_0_valid  input  1 and port data_in_0_ready  output  1: input handshake.
REQ-011 SHALL have port data_out_0  output  [PRECISION_0-1:0] x PARALLELISM_DIM_0 unpacked  x - max(vector), same format as input.
REQ-012 SHALL have port data_out_0_valid  output  1 and port data_out_0_ready  input  1: output handshake.

Function
REQ-013 SHALL implement states FILL and DRAIN; a transfer SHALL occur only when valid and ready are both high in the same cycle.
REQ-014 In FILL: data_in_0_ready=1, data_out_0_valid=0; each accepted beat SHALL be written to buffer[wr_idx], and the running max SHALL be updated with the max of its lanes.
REQ-015 The running max SHALL load the first beat's lane-max unconditionally (no carry-over from the previous vector).
REQ-016 When beat IN_0_DEPTH-1 is accepted: the state SHALL change to DRAIN, wr_idx SHALL wrap to 0, and the final max SHALL be latched.
REQ-017 In DRAIN: data_in_0_ready=0, data_out_0_valid=1; data_out_0[k] SHALL equal buffer[rd_idx][k] - max, computed at PRECISION_0+1 bits and then reduced per REQ-026/027.
REQ-018 rd_idx SHALL advance only on an output handshake; data_out_0 SHALL hold stable while valid=1 and ready=0.
REQ-019 On the handshake of beat IN_0_DEPTH-1: the state SHALL change to FILL, rd_idx SHALL wrap to 0, and ready SHALL be 1 the next cycle.
REQ-020 Latency: the first output beat SHALL be valid the cycle after the last input beat is accepted; with no backpressure, one vector SHALL take 2*IN_0_DEPTH cycles.
REQ-021 In FILL, data_out_0_ready SHALL be ignored; in DRAIN, data_in_0_valid SHALL be ignored and no input SHALL be lost.
REQ-022 IN_0_DEPTH=1 SHALL work: FILL->DRAIN->FILL on successive handshakes.
REQ-023 Every result SHALL be <=0; a vector of equal elements SHALL produce all zeros.

Reset
REQ-024 Asserting rst (low) at any time, including mid-FILL or mid-DRAIN, SHALL immediately force: state=FILL, wr_idx=rd_idx=0, running max = most-negative value, data_out_0_valid=0, data_in_0_ready=1; any partial vector SHALL be discarded.
REQ-025 Buffer contents need not be reset; data_out_0 SHALL be don't-care while valid=0.

Configuration
REQ-026 With macro FIXED_MAX_NORMALIZE_SAT_EN defined: differences below -2^(PRECISION_0-1) SHALL saturate to -2^(PRECISION_0-1).
REQ-027 Without FIXED_MAX_NORMALIZE_SAT_EN: the difference SHALL be truncated to the low PRECISION_0 bits (wrap).

Structure
REQ-028 The shared package fixed_max_normalize_pkg SHALL hold the state enum (FILL, DRAIN) and the saturate-to-width function.
REQ-029 One sub-module SHALL exist: fixed_lane_max, a combinational signed max tree over PARALLELISM_DIM_0 lanes; it SHALL be bypassed when PARALLELISM_DIM_0=1.

Verification
REQ-030 Defaults, inputs 0..9 (raw), ready=1 -> outputs -9..0 in order; first out valid exactly 1 cycle after the 10th input handshake.
REQ-031 All inputs 0x30 -> ten outputs 0x00; then a second vector streamed straight after -> correct result, with no max carried over from the first vector.
REQ-032 Vector {-128, 127, 0 x8}, SAT_EN defined -> first output -128 (saturated); without the macro -> 0x01 (wrapped).
REQ-033 PARALLELISM_DIM_0=2, beats {(3,-5),(7,1),...} -> max taken across lanes and beats; outputs match the golden model lane-for-lane.
REQ-034 Random data_out_0_ready toggling in DRAIN -> data held stable, no beat dropped or duplicated; data_in_0_ready=0 for the whole of DRAIN.
REQ-035 rst pulsed low after 4 outputs of a vector -> valid=0 and ready=1 immediately; the next full vector is processed correctly.
